// File: rtl/qpu_measure_pkg.sv
// Shared definitions for the measurement-result collector: FSM encoding and default sizes.
package qpu_measure_pkg;

    localparam int QUBIT_NUM_DEF = 12;
    localparam int QIDX_W_DEF    = 4;
    localparam int TMO_W_DEF     = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

endpackage

// File: rtl/qpu_measure_collect_if.sv
// Request / readout / commit bundle between the OITF + MCU side (master) and the collector (slave).
interface qpu_measure_collect_if #(
    parameter int QUBIT_NUM = qpu_measure_pkg::QUBIT_NUM_DEF,
    parameter int QIDX_W    = qpu_measure_pkg::QIDX_W_DEF
);
    logic                 meas_req_valid;
    logic [QUBIT_NUM-1:0] meas_req_list;
    logic                 meas_req_ready;

    logic                 res_valid;
    logic [QIDX_W-1:0]    res_qidx;
    logic                 res_bit;

    logic                 meas_wen;
    logic [QUBIT_NUM-1:0] meas_data;
    logic [QUBIT_NUM-1:0] meas_list;

    modport master (
        output meas_req_valid, meas_req_list, res_valid, res_qidx, res_bit,
        input  meas_req_ready, meas_wen, meas_data, meas_list
    );

    modport slave (
        input  meas_req_valid, meas_req_list, res_valid, res_qidx, res_bit,
        output meas_req_ready, meas_wen, meas_data, meas_list
    );
endinterface

// File: rtl/qpu_meas_timer.sv
// Saturating COLLECT-cycle counter; expire flags the last allowed cycle before a forced commit.
module qpu_meas_timer #(
    parameter int TMO_W = qpu_measure_pkg::TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);
    import qpu_measure_pkg::*;

    logic [TMO_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + TMO_W'(1);
        end
    end

    // A zero limit means "never expire".
    assign expire = en && (limit != '0) && (cnt_reg == limit - TMO_W'(1));

endmodule

// File: rtl/qpu_measure_collect.sv
// Gathers per-qubit readout results for one in-flight measure list and commits them as one write pulse.
module qpu_measure_collect #(
    parameter int QUBIT_NUM = qpu_measure_pkg::QUBIT_NUM_DEF,
    parameter int QIDX_W    = qpu_measure_pkg::QIDX_W_DEF,
    parameter int TMO_W     = qpu_measure_pkg::TMO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    qpu_measure_collect_if.slave  bus,
    input  logic [TMO_W-1:0]      timeout_cycles,
    input  logic                  err_clr,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  stray_err
);
    import qpu_measure_pkg::*;

    state_t               state_reg, state_next;
    logic [QUBIT_NUM-1:0] pending_reg, pending_next;
    logic [QUBIT_NUM-1:0] data_reg, data_next;
    logic [QUBIT_NUM-1:0] list_reg, list_next;
    logic [TMO_W-1:0]     tmo_reg, tmo_next;
    logic                 wen_reg;
    logic [QUBIT_NUM-1:0] mdata_reg, mlist_reg;
    logic                 timeout_err_reg, stray_err_reg;

    logic [QUBIT_NUM-1:0] hit;
    logic                 accept_list;
    logic                 tmo_set;
    logic                 stray_set;
    logic                 expire;
    logic                 in_collect;

    assign in_collect = (state_reg == ST_COLLECT);

    // One-hot decode of the incoming result; an out-of-range index simply matches nothing.
    generate
        for (genvar gi = 0; gi < QUBIT_NUM; gi++) begin : g_hit
            assign hit[gi] = in_collect && bus.res_valid &&
                             (bus.res_qidx == QIDX_W'(gi)) && pending_reg[gi];
        end
    endgenerate

    assign stray_set = bus.res_valid && (hit == '0);

    qpu_meas_timer #(.TMO_W(TMO_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_list),
        .en     (in_collect),
        .limit  (tmo_reg),
        .expire (expire)
    );

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        data_next    = data_reg;
        list_next    = list_reg;
        tmo_next     = tmo_reg;
        accept_list  = 1'b0;
        tmo_set      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // An empty list is accepted and silently dropped.
                if (bus.meas_req_valid && (bus.meas_req_list != '0)) begin
                    accept_list  = 1'b1;
                    list_next    = bus.meas_req_list;
                    pending_next = bus.meas_req_list;
                    data_next    = '0;
                    tmo_next     = timeout_cycles;
                    state_next   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                pending_next = pending_reg & ~hit;
                data_next    = (data_reg & ~hit) | (hit & {QUBIT_NUM{bus.res_bit}});
                // Completion takes priority over a timeout landing on the same cycle.
                if (pending_next == '0) begin
                    state_next = ST_COMMIT;
                end else if (expire) begin
                    state_next = ST_COMMIT;
                    tmo_set    = 1'b1;
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pending_reg     <= '0;
            data_reg        <= '0;
            list_reg        <= '0;
            tmo_reg         <= '0;
            wen_reg         <= 1'b0;
            mdata_reg       <= '0;
            mlist_reg       <= '0;
            timeout_err_reg <= 1'b0;
            stray_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            data_reg        <= data_next;
            list_reg        <= list_next;
            tmo_reg         <= tmo_next;
            wen_reg         <= (state_next == ST_COMMIT);
            mdata_reg       <= (state_next == ST_COMMIT) ? data_next : '0;
            mlist_reg       <= (state_next == ST_COMMIT) ? list_next : '0;
            timeout_err_reg <= tmo_set   | (timeout_err_reg & ~err_clr);
            stray_err_reg   <= stray_set | (stray_err_reg   & ~err_clr);
        end
    end

    assign bus.meas_req_ready = (state_reg == ST_IDLE);
    assign bus.meas_wen       = wen_reg;
    assign bus.meas_data      = mdata_reg;
    assign bus.meas_list      = mlist_reg;
    assign busy               = (state_reg != ST_IDLE);
    assign timeout_err        = timeout_err_reg;
    assign stray_err          = stray_err_reg;

endmodule

// File: tb/tb_qpu_measure_collect.sv
// Bench for qpu_measure_collect: table vectors, directed corner sequences and a random run vs a list-level model.
module tb_qpu_measure_collect;
    import qpu_measure_pkg::*;

    localparam int QN = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] timeout_cycles;
    logic        err_clr;
    logic        busy, timeout_err, stray_err;

    qpu_measure_collect_if #(.QUBIT_NUM(QN), .QIDX_W(4)) bus ();

    qpu_measure_collect dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .timeout_cycles (timeout_cycles),
        .err_clr        (err_clr),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .stray_err      (stray_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // List-level reference: a queue of qubits still owed, cycle stamps for the timeout.
    bit          m_collecting, m_pulse;
    int          m_wait[$];
    bit [QN-1:0] m_val, m_list;
    int          m_accept_cyc, m_limit, cyc;
    bit          m_tmo, m_stray;

    function automatic void model_reset();
        m_collecting = 0; m_pulse = 0; m_wait.delete();
        m_val = '0; m_list = '0; m_accept_cyc = 0; m_limit = 0;
        m_tmo = 0; m_stray = 0;
    endfunction

    function automatic void model_edge();
        bit stray_now = 0;
        bit tmo_now = 0;
        int pos = -1;
        cyc++;
        if (m_pulse) begin
            m_pulse = 0;
            if (bus.res_valid) stray_now = 1;
        end else if (m_collecting) begin
            if (bus.res_valid) begin
                foreach (m_wait[i]) if (m_wait[i] == int'(bus.res_qidx)) pos = i;
                if (pos >= 0) begin
                    m_val[bus.res_qidx] = bus.res_bit;
                    m_wait.delete(pos);
                end else begin
                    stray_now = 1;
                end
            end
            if (m_wait.size() == 0) begin
                m_collecting = 0; m_pulse = 1;
            end else if (m_limit != 0 && (cyc - m_accept_cyc) == m_limit) begin
                m_collecting = 0; m_pulse = 1; tmo_now = 1;
            end
        end else begin
            if (bus.res_valid) stray_now = 1;
            if (bus.meas_req_valid && bus.meas_req_list != '0) begin
                m_collecting = 1;
                m_list = bus.meas_req_list;
                m_val = '0;
                m_wait.delete();
                for (int k = 0; k < QN; k++) if (m_list[k]) m_wait.push_back(k);
                m_limit = int'(timeout_cycles);
                m_accept_cyc = cyc;
            end
        end
        m_tmo   = tmo_now   || (m_tmo   && !err_clr);
        m_stray = stray_now || (m_stray && !err_clr);
    endfunction

    task automatic compare_model();
        bit act_c = m_collecting || m_pulse;
        check("ready",       32'(bus.meas_req_ready), 32'(!act_c));
        check("busy",        32'(busy),               32'(act_c));
        check("wen",         32'(bus.meas_wen),       32'(m_pulse));
        check("data",        32'(bus.meas_data),      m_pulse ? 32'(m_val)  : 32'h0);
        check("list",        32'(bus.meas_list),      m_pulse ? 32'(m_list) : 32'h0);
        check("timeout_err", 32'(timeout_err),        32'(m_tmo));
        check("stray_err",   32'(stray_err),          32'(m_stray));
    endtask

    task automatic tick();
        if (rst) model_reset();
        else     model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        bus.meas_req_valid = 1'b0;
        bus.meas_req_list  = '0;
        bus.res_valid      = 1'b0;
        bus.res_qidx       = '0;
        bus.res_bit        = 1'b0;
        err_clr            = 1'b0;
    endtask

    task automatic accept(input logic [QN-1:0] list, input logic [15:0] tmo);
        bus.meas_req_valid = 1'b1;
        bus.meas_req_list  = list;
        timeout_cycles     = tmo;
        tick();
        bus.meas_req_valid = 1'b0;
        bus.meas_req_list  = '0;
    endtask

    task automatic send_res(input int q, input logic b);
        bus.res_valid = 1'b1;
        bus.res_qidx  = 4'(q);
        bus.res_bit   = b;
        tick();
        bus.res_valid = 1'b0;
    endtask

    typedef struct {
        logic [QN-1:0] list;
        logic [QN-1:0] bits;
        logic [QN-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{list: 12'h005, bits: 12'h001, exp_data: 12'h001};
        vecs[1] = '{list: 12'h0C0, bits: 12'hFFF, exp_data: 12'h0C0};
        vecs[2] = '{list: 12'h800, bits: 12'h800, exp_data: 12'h800};
        vecs[3] = '{list: 12'hFFF, bits: 12'hA5A, exp_data: 12'hA5A};
        vecs[4] = '{list: 12'h001, bits: 12'h000, exp_data: 12'h000};

        cyc = 0;
        rst = 1'b1;
        timeout_cycles = '0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready",  32'(bus.meas_req_ready), 32'h1);
        check("rst_busy",   32'(busy),               32'h0);
        check("rst_wen",    32'(bus.meas_wen),       32'h0);
        check("rst_data",   32'(bus.meas_data),      32'h0);
        check("rst_list",   32'(bus.meas_list),      32'h0);
        check("rst_tmo",    32'(timeout_err),        32'h0);
        check("rst_stray",  32'(stray_err),          32'h0);
        tick();

        // Table: every listed qubit returned back-to-back in ascending order.
        foreach (vecs[i]) begin
            accept(vecs[i].list, 16'd0);
            for (int k = 0; k < QN; k++) if (vecs[i].list[k]) send_res(k, vecs[i].bits[k]);
            check($sformatf("vec%0d_wen", i),   32'(bus.meas_wen),  32'h1);
            check($sformatf("vec%0d_data", i),  32'(bus.meas_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_list", i),  32'(bus.meas_list), 32'(vecs[i].list));
            check($sformatf("vec%0d_errs", i),  32'({timeout_err, stray_err}), 32'h0);
            tick();
            check($sformatf("vec%0d_ready", i), 32'(bus.meas_req_ready), 32'h1);
        end

        // Full return with a gap: accept at t, q0 at t+1, q2 at t+3, pulse at t+4.
        accept(12'h005, 16'd0);
        send_res(0, 1'b1);
        tick();
        check("gap_wen_early", 32'(bus.meas_wen), 32'h0);
        send_res(2, 1'b0);
        check("gap_wen",  32'(bus.meas_wen),  32'h1);
        check("gap_data", 32'(bus.meas_data), 32'h001);
        check("gap_list", 32'(bus.meas_list), 32'h005);
        tick();

        // Out-of-order finish.
        accept(12'h0C0, 16'd0);
        send_res(7, 1'b1);
        check("ooo_wen_early", 32'(bus.meas_wen), 32'h0);
        send_res(6, 1'b1);
        check("ooo_wen",  32'(bus.meas_wen),  32'h1);
        check("ooo_data", 32'(bus.meas_data), 32'h0C0);
        tick();

        // Timeout: 8 COLLECT cycles, q0 never returns.
        accept(12'h003, 16'd8);
        send_res(1, 1'b1);
        n = 1;
        while (!bus.meas_wen && n < 50) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n),             32'd8);
        check("tmo_data",    32'(bus.meas_data), 32'h002);
        check("tmo_list",    32'(bus.meas_list), 32'h003);
        check("tmo_err",     32'(timeout_err),   32'h1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_clr", 32'(timeout_err), 32'h0);

        // Result completing the list on the timeout cycle: no timeout error.
        accept(12'h003, 16'd2);
        send_res(0, 1'b1);
        send_res(1, 1'b1);
        check("tmo_race_wen", 32'(bus.meas_wen), 32'h1);
        check("tmo_race_err", 32'(timeout_err),  32'h0);
        tick();

        // Strays.
        send_res(3, 1'b1);
        check("stray_idle", 32'(stray_err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stray_clr", 32'(stray_err), 32'h0);
        accept(12'h003, 16'd0);
        send_res(14, 1'b1);
        check("stray_range", 32'(stray_err), 32'h1);
        send_res(0, 1'b1);
        err_clr = 1'b1;
        send_res(0, 1'b0);
        err_clr = 1'b0;
        check("stray_set_wins", 32'(stray_err), 32'h1);
        send_res(1, 1'b0);
        check("stray_dup_data", 32'(bus.meas_data), 32'h001);
        tick();

        // Flow control: second request held valid during COLLECT.
        accept(12'h010, 16'd0);
        bus.meas_req_valid = 1'b1;
        bus.meas_req_list  = 12'h020;
        tick();
        check("fc_ready_collect", 32'(bus.meas_req_ready), 32'h0);
        send_res(4, 1'b1);
        bus.meas_req_valid = 1'b1;
        check("fc_ready_commit", 32'(bus.meas_req_ready), 32'h0);
        tick();
        check("fc_ready_after", 32'(bus.meas_req_ready), 32'h1);
        tick();
        bus.meas_req_valid = 1'b0;
        check("fc_second_busy", 32'(busy), 32'h1);
        send_res(5, 1'b0);
        check("fc_second_list", 32'(bus.meas_list), 32'h020);
        tick();
        bus.meas_req_valid = 1'b1;
        bus.meas_req_list  = 12'h000;
        tick();
        bus.meas_req_valid = 1'b0;
        check("zero_busy", 32'(busy), 32'h0);
        tick();
        check("zero_wen", 32'(bus.meas_wen), 32'h0);

        // Asynchronous reset mid-COLLECT.
        accept(12'h0F0, 16'd0);
        send_res(4, 1'b1);
        bus.res_valid = 1'b1;
        bus.res_qidx  = 4'd15;
        tick();
        bus.res_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_ready", 32'(bus.meas_req_ready), 32'h1);
        check("arst_busy",  32'(busy),               32'h0);
        check("arst_errs",  32'({timeout_err, stray_err}), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_res(5 + i, 1'b1);
            check("arst_no_wen", 32'(bus.meas_wen), 32'h0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Random traffic against the model (compare_model runs every tick).
        for (int c = 0; c < 1500; c++) begin
            bus.meas_req_valid = ($urandom_range(0, 3) == 0);
            bus.meas_req_list  = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            timeout_cycles     = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            bus.res_valid      = ($urandom_range(0, 1) == 1);
            bus.res_qidx       = 4'($urandom_range(0, 15));
            bus.res_bit        = 1'($urandom);
            err_clr            = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
